// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-register control fields and hazard controller outputs
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             idex_mem_read;
    logic [4:0]       idex_rt;
    logic             exmem_mem_read;
    logic             exmem_mem_write;
    logic             branch_taken;
    logic             dmem_ack;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             idex_bubble;
    logic             ifid_flush;
    logic             dmem_req;
    logic [CNT_W-1:0] stall_count;
    logic             timeout_err;
    logic [1:0]       state;

    modport master (
        input  ifid_rs, ifid_rt, idex_mem_read, idex_rt,
               exmem_mem_read, exmem_mem_write, branch_taken, dmem_ack,
        output pc_write, ifid_write, idex_write, exmem_write,
               idex_bubble, ifid_flush, dmem_req, stall_count, timeout_err, state
    );

    modport slave (
        output ifid_rs, ifid_rt, idex_mem_read, idex_rt,
               exmem_mem_read, exmem_mem_write, branch_taken, dmem_ack,
        input  pc_write, ifid_write, idex_write, exmem_write,
               idex_bubble, ifid_flush, dmem_req, stall_count, timeout_err, state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use/branch/memory-wait hazard controller with stall counter
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.master hz
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1
    } state_t;

    state_t             st;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   stall_cnt;
    logic               err;

    logic mem_op;
    logic load_use;

    assign mem_op   = hz.exmem_mem_read | hz.exmem_mem_write;
    assign load_use = hz.idex_mem_read && (hz.idex_rt != 5'd0) &&
                      ((hz.idex_rt == hz.ifid_rs) || (hz.idex_rt == hz.ifid_rt));

    // Default is a full freeze, which is also what reset and MEM_WAIT present.
    always_comb begin
        hz.pc_write    = 1'b0;
        hz.ifid_write  = 1'b0;
        hz.idex_write  = 1'b0;
        hz.exmem_write = 1'b0;
        hz.idex_bubble = 1'b0;
        hz.ifid_flush  = 1'b0;
        hz.dmem_req    = 1'b0;
        if (!reset) begin
            case (st)
                RUN: begin
                    hz.dmem_req = mem_op;
                    if (mem_op && !hz.dmem_ack) begin
                        hz.pc_write = 1'b0;
                    end else if (hz.branch_taken) begin
                        hz.pc_write    = 1'b1;
                        hz.ifid_write  = 1'b1;
                        hz.idex_write  = 1'b1;
                        hz.exmem_write = 1'b1;
                        hz.idex_bubble = 1'b1;
                        hz.ifid_flush  = 1'b1;
                    end else if (load_use) begin
                        hz.idex_write  = 1'b1;
                        hz.exmem_write = 1'b1;
                        hz.idex_bubble = 1'b1;
                    end else begin
                        hz.pc_write    = 1'b1;
                        hz.ifid_write  = 1'b1;
                        hz.idex_write  = 1'b1;
                        hz.exmem_write = 1'b1;
                    end
                end
                MEM_WAIT: hz.dmem_req = 1'b1;
                default:  hz.dmem_req = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (!hz.pc_write && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            case (st)
                RUN: begin
                    if (mem_op && !hz.dmem_ack) begin
                        st       <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (hz.dmem_ack) begin
                        st       <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        // Counter parks at TIMEOUT; the error stays set until reset.
                        if (wait_cnt != WAIT_W'(TIMEOUT))
                            wait_cnt <= wait_cnt + 1'b1;
                        else
                            err <= 1'b1;
                    end
                end
                default: st <= RUN;
            endcase
        end
    end

    assign hz.stall_count = stall_cnt;
    assign hz.timeout_err = err;
    assign hz.state       = st;
endmodule
